ara_inval_line_walker: RTL and testbench
========================================

Name: ara_inval_line_walker

Overview:
- Expands write-burst descriptors (address, len, size) from Ara's AXI AW path into one L1 D-cache line invalidation request per line touched.
- Sits between the AW-side invalidation filter and the CVA6 accelerator-response invalidation port (inval_addr/inval_valid/inval_ready).
- Optionally suppresses back-to-back invalidations of the same line, saving CVA6 D-cache cycles on streaming vector stores.

Parameters:
AddrWidth, 64, address width of descriptors and invalidation addresses
L1LineWidth, 16, L1 D-cache line size in bytes; power of two, >= 8
Dedup, 1, 1 = drop an invalidation equal to the last emitted line; 0 = never drop

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
en_i  input  1  coherence enable; sampled only at descriptor accept
flush_i  input  1  clears the dedup history
desc_valid_i  input  1  burst descriptor valid
desc_ready_o  output  1  descriptor accepted when valid&&ready
desc_addr_i  input  AddrWidth  AXI AW start address
desc_len_i  input  8  AXI beats minus one
desc_size_i  input  3  AXI log2(bytes per beat)
inval_valid_o  output  1  invalidation request valid
inval_ready_i  input  1  CVA6 accepts invalidation
inval_addr_o  output  AddrWidth  line-aligned address to invalidate
busy_o  output  1  high while a burst is being walked

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE, inval_valid_o=0, inval_addr_o=0, busy_o=0, history valid bit=0, cur/last registers=0. Reset mid-burst aborts the walk; no further requests issue.
- States: IDLE, EMIT.
- desc_ready_o = (state==IDLE). In EMIT, descriptors are back-pressured.
- Accept arithmetic (combinational in the accept cycle, all modulo 2^AddrWidth):
  - base = desc_addr_i & ~((1<<desc_size_i)-1)
  - end = base + ((desc_len_i+1) << desc_size_i) - 1
  - first = desc_addr_i & ~(L1LineWidth-1)
  - last = end & ~(L1LineWidth-1)
- Accept with en_i=0: descriptor consumed and dropped. Stay IDLE; history unchanged.
- Accept with en_i=1:
  - If Dedup and history valid and first==hist, first is skipped: cur=first+L1LineWidth.
  - If first==last in that case, the whole descriptor is dropped and the block stays IDLE.
  - Otherwise cur=first (or first+L1LineWidth when skipped), store last, go to EMIT.
- EMIT:
  - inval_valid_o=1, inval_addr_o=cur, busy_o=1. First request is valid the cycle after accept.
  - Address is held stable while inval_ready_i=0 (AXI-style: valid never drops without a handshake).
  - On handshake: hist=cur, history valid=1. If cur==last go to IDLE, else cur+=L1LineWidth.
  - Throughput is one line per cycle under continuous ready.
- Termination uses equality, not magnitude, so a burst wrapping past the top of the address space walks through 0 correctly.
- en_i changes during EMIT are ignored; the current burst completes.
- flush_i=1 clears history valid. If a handshake occurs in the same cycle, flush wins (history ends invalid).
- Outputs are registered (state, cur); inval_ready_i has no combinational path to inval_valid_o.
- IDLE outputs: inval_valid_o=0, busy_o=0. inval_addr_o holds its last value.

Test Plan:
1. L1LineWidth=16, Dedup=0: desc addr=0x1000, len=3, size=3 -> inval 0x1000, then 0x1010 on consecutive cycles. busy_o high for 2 cycles, then desc_ready_o=1.
2. Unaligned start: addr=0x100C, len=1, size=2 (bytes 0x100C–0x1013) -> 0x1000, 0x1010.
3. Dedup=1 after test 1:
   - desc addr=0x1018, len=0, size=3 -> dropped, inval_valid_o stays 0, desc_ready_o stays 1.
   - Then addr=0x1018, len=1, size=3 -> only 0x1020.
   - With flush_i pulsed between the two -> 0x1010, 0x1020.
4. Backpressure: hold inval_ready_i=0 for 3 cycles during test 1 -> inval_addr_o stays 0x1000 with valid high throughout. desc_valid_i held high is not accepted until the walk ends.
5. Wrap and enable: addr=0xFFFF_FFFF_FFFF_FFF0, len=3, size=3 -> 0xFFFF_FFFF_FFFF_FFF0, then 0x0. Same descriptor with en_i=0 -> accepted in one cycle, no inval_valid_o.
6. Reset mid-burst: len=15, size=3 at 0x2000; assert rst_i after the 2nd handshake -> next cycle inval_valid_o=0, busy_o=0, desc_ready_o=1, inval_addr_o=0, history cleared (a repeat of 0x2000 is emitted).

Source files
------------

// File: rtl/ara_inval_line_walker.sv
// Line walker: expands AXI AW write-burst descriptors into one L1 D-cache
// line invalidation per line touched. Optionally drops an invalidation that
// would repeat the most recently emitted line.
module ara_inval_line_walker #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter bit          Dedup       = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic [7:0]           desc_len_i,
  input  logic [2:0]           desc_size_i,
  output logic                 inval_valid_o,
  input  logic                 inval_ready_i,
  output logic [AddrWidth-1:0] inval_addr_o,
  output logic                 busy_o
);

  localparam logic [AddrWidth-1:0] LineBytes = AddrWidth'(L1LineWidth);
  localparam logic [AddrWidth-1:0] LineMask  = ~(LineBytes - AddrWidth'(1));

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   cur_q, cur_d;
  logic [AddrWidth-1:0]   last_q, last_d;
  logic [AddrWidth-1:0]   hist_q, hist_d;
  logic                   hist_valid_q, hist_valid_d;

  logic [AddrWidth-1:0]   size_mask;
  logic [AddrWidth-1:0]   base_addr;
  logic [AddrWidth-1:0]   span_bytes;
  logic [AddrWidth-1:0]   end_addr;
  logic [AddrWidth-1:0]   first_line;
  logic [AddrWidth-1:0]   last_line;
  logic                   skip_first;

  // Descriptor decode: first and last line touched by the burst (wraps mod 2^AddrWidth).
  always_comb begin
    size_mask  = (AddrWidth'(1) << desc_size_i) - AddrWidth'(1);
    base_addr  = desc_addr_i & ~size_mask;
    span_bytes = AddrWidth'({1'b0, desc_len_i} + 9'd1) << desc_size_i;
    end_addr   = base_addr + span_bytes - AddrWidth'(1);
    first_line = desc_addr_i & LineMask;
    last_line  = end_addr & LineMask;
    skip_first = Dedup && hist_valid_q && (first_line == hist_q);
  end

  // Next-state logic: accept descriptors in IDLE, step one line per handshake in EMIT.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    hist_d       = hist_q;
    hist_valid_d = hist_valid_q;

    unique case (state_q)
      IDLE: begin
        // With en_i low the descriptor is still consumed, just ignored.
        if (desc_valid_i && en_i) begin
          if (!(skip_first && (first_line == last_line))) begin
            cur_d   = skip_first ? (first_line + LineBytes) : first_line;
            last_d  = last_line;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (inval_ready_i) begin
          hist_d       = cur_q;
          hist_valid_d = 1'b1;
          // Equality (not magnitude) so bursts wrapping through 0 terminate correctly.
          if (cur_q == last_q) begin
            state_d = IDLE;
          end else begin
            cur_d = cur_q + LineBytes;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides a same-cycle handshake: history ends invalid.
    if (flush_i) begin
      hist_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      hist_q       <= '0;
      hist_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      hist_q       <= hist_d;
      hist_valid_q <= hist_valid_d;
    end
  end

  // Outputs come straight from registers; no combinational path from inval_ready_i.
  assign desc_ready_o  = (state_q == IDLE);
  assign inval_valid_o = (state_q == EMIT);
  assign busy_o        = (state_q == EMIT);
  assign inval_addr_o  = cur_q;

endmodule

// File: tb/tb_ara_inval_line_walker.sv
// Directed testbench for ara_inval_line_walker (64-bit addresses, 16-byte
// lines, dedup enabled). Inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_ara_inval_line_walker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        desc_valid_i = 1'b0;
  logic        desc_ready_o;
  logic [63:0] desc_addr_i = '0;
  logic [7:0]  desc_len_i = '0;
  logic [2:0]  desc_size_i = '0;
  logic        inval_valid_o;
  logic        inval_ready_i = 1'b1;
  logic [63:0] inval_addr_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  logic [63:0] got[$];
  int          busy_cycles;
  int          send_waits;

  ara_inval_line_walker #(
    .AddrWidth  (64),
    .L1LineWidth(16),
    .Dedup      (1'b1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .flush_i      (flush_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .desc_addr_i  (desc_addr_i),
    .desc_len_i   (desc_len_i),
    .desc_size_i  (desc_size_i),
    .inval_valid_o(inval_valid_o),
    .inval_ready_i(inval_ready_i),
    .inval_addr_o (inval_addr_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a descriptor, wait (bounded) for ready, hold it for exactly the accept edge.
  task automatic send(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                      input logic en);
    desc_addr_i  = a;
    desc_len_i   = l;
    desc_size_i  = s;
    en_i         = en;
    desc_valid_i = 1'b1;
    send_waits   = 0;
    while (!desc_ready_o && send_waits < 100) begin
      step();
      send_waits++;
    end
    if (send_waits >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: desc_ready_o never rose for addr %h", a);
    end
    step();
    desc_valid_i = 1'b0;
    en_i         = 1'b1;
  endtask

  // Collect handshaken addresses until the walk ends (bounded).
  task automatic drain();
    got.delete();
    busy_cycles = 0;
    while (busy_o && busy_cycles < 200) begin
      if (inval_valid_o && inval_ready_i) got.push_back(inval_addr_o);
      busy_cycles++;
      step();
    end
    if (busy_cycles >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: busy_o stuck high");
    end
  endtask

  task automatic check_got(input string name, input logic [63:0] exp[$]);
    checks++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d lines, expected %0d", name, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          failures++;
          $display("FAIL %s_line%0d: got %h, expected %h", name, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({inval_valid_o, busy_o, desc_ready_o} !== 3'b001) begin
      failures++;
      $display("FAIL reset_ctrl: valid/busy/ready=%b, expected 001",
               {inval_valid_o, busy_o, desc_ready_o});
    end
    checks++;
    if (inval_addr_o !== 64'h0) begin
      failures++;
      $display("FAIL reset_addr: got %h, expected 0", inval_addr_o);
    end
  endtask

  task automatic test_aligned();
    do_reset();
    inval_ready_i = 1'b1;
    send(64'h1000, 8'd3, 3'd3, 1'b1);
    checks++;
    if (!(inval_valid_o === 1'b1 && inval_addr_o === 64'h1000 && desc_ready_o === 1'b0)) begin
      failures++;
      $display("FAIL aligned_first: valid=%b addr=%h ready=%b, expected 1/1000/0",
               inval_valid_o, inval_addr_o, desc_ready_o);
    end
    drain();
    check_got("aligned", '{64'h1000, 64'h1010});
    checks++;
    if (busy_cycles != 2) begin
      failures++;
      $display("FAIL aligned_busy: busy %0d cycles, expected 2", busy_cycles);
    end
    checks++;
    if (!(desc_ready_o === 1'b1 && inval_addr_o === 64'h1010)) begin
      failures++;
      $display("FAIL aligned_idle: ready=%b addr=%h, expected 1/1010", desc_ready_o, inval_addr_o);
    end
  endtask

  task automatic test_unaligned();
    do_reset();
    send(64'h100C, 8'd1, 3'd2, 1'b1);
    drain();
    check_got("unaligned", '{64'h1000, 64'h1010});
  endtask

  task automatic test_dedup();
    // History = 0x1010 after the aligned burst.
    do_reset();
    send(64'h1000, 8'd3, 3'd3, 1'b1);
    drain();
    send(64'h1018, 8'd0, 3'd3, 1'b1);
    checks++;
    if (!(inval_valid_o === 1'b0 && busy_o === 1'b0 && desc_ready_o === 1'b1)) begin
      failures++;
      $display("FAIL dedup_drop: valid=%b busy=%b ready=%b, expected 0/0/1",
               inval_valid_o, busy_o, desc_ready_o);
    end
    send(64'h1018, 8'd1, 3'd3, 1'b1);
    drain();
    check_got("dedup_skip", '{64'h1020});

    // Same sequence with a flush between: history is forgotten.
    do_reset();
    send(64'h1000, 8'd3, 3'd3, 1'b1);
    drain();
    send(64'h1018, 8'd0, 3'd3, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    send(64'h1018, 8'd1, 3'd3, 1'b1);
    drain();
    check_got("dedup_flush", '{64'h1010, 64'h1020});
  endtask

  task automatic test_backpressure();
    do_reset();
    inval_ready_i = 1'b0;
    send(64'h1000, 8'd3, 3'd3, 1'b1);
    // A second descriptor waits on the input while the walk is stalled.
    desc_addr_i  = 64'h3000;
    desc_len_i   = 8'd0;
    desc_size_i  = 3'd3;
    desc_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!(inval_valid_o === 1'b1 && inval_addr_o === 64'h1000 && desc_ready_o === 1'b0)) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b addr=%h ready=%b, expected 1/1000/0",
                 i, inval_valid_o, inval_addr_o, desc_ready_o);
      end
      if (i < 2) step();
    end
    inval_ready_i = 1'b1;
    step();
    checks++;
    if (!(inval_valid_o === 1'b1 && inval_addr_o === 64'h1010 && desc_ready_o === 1'b0)) begin
      failures++;
      $display("FAIL bp_second: valid=%b addr=%h ready=%b, expected 1/1010/0",
               inval_valid_o, inval_addr_o, desc_ready_o);
    end
    step();
    checks++;
    if (!(desc_ready_o === 1'b1 && inval_valid_o === 1'b0)) begin
      failures++;
      $display("FAIL bp_end: ready=%b valid=%b, expected 1/0", desc_ready_o, inval_valid_o);
    end
    step();
    desc_valid_i = 1'b0;
    checks++;
    if (!(inval_valid_o === 1'b1 && inval_addr_o === 64'h3000)) begin
      failures++;
      $display("FAIL bp_queued: valid=%b addr=%h, expected 1/3000", inval_valid_o, inval_addr_o);
    end
    drain();
    check_got("bp_queued", '{64'h3000});
  endtask

  task automatic test_wrap_enable();
    do_reset();
    send(64'hFFFF_FFFF_FFFF_FFF0, 8'd3, 3'd3, 1'b1);
    drain();
    check_got("wrap", '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0});
    send(64'hFFFF_FFFF_FFFF_FFF0, 8'd3, 3'd3, 1'b0);
    checks++;
    if (send_waits != 0) begin
      failures++;
      $display("FAIL disabled_wait: waited %0d cycles, expected 0", send_waits);
    end
    checks++;
    if (!(inval_valid_o === 1'b0 && busy_o === 1'b0 && desc_ready_o === 1'b1)) begin
      failures++;
      $display("FAIL disabled_drop: valid=%b busy=%b ready=%b, expected 0/0/1",
               inval_valid_o, busy_o, desc_ready_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    send(64'h2000, 8'd15, 3'd3, 1'b1);
    step();
    step();
    checks++;
    if (inval_addr_o !== 64'h2020) begin
      failures++;
      $display("FAIL midrst_pre: addr %h, expected 2020", inval_addr_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++;
    if (!(inval_valid_o === 1'b0 && busy_o === 1'b0 && desc_ready_o === 1'b1 &&
          inval_addr_o === 64'h0)) begin
      failures++;
      $display("FAIL midrst_state: valid=%b busy=%b ready=%b addr=%h, expected 0/0/1/0",
               inval_valid_o, busy_o, desc_ready_o, inval_addr_o);
    end
    step();
    checks++;
    if (inval_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet: valid=%b, expected 0", inval_valid_o);
    end
    // 0x2010 was the last handshaken line; it must be emitted again.
    send(64'h2010, 8'd0, 3'd3, 1'b1);
    drain();
    check_got("midrst_hist", '{64'h2010});
    send(64'h2000, 8'd0, 3'd3, 1'b1);
    drain();
    check_got("midrst_repeat", '{64'h2000});
  endtask

  initial begin
    #1;
    test_reset();
    test_aligned();
    test_unaligned();
    test_dedup();
    test_backpressure();
    test_wrap_enable();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
